// File: rtl/hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// hazard_unit_pkg
// Shared CPU definitions: RV32I major opcodes, hazard FSM state encoding and
// register-use helpers for the decoder, forwarding and hazard logic.
// Revision: 1.0  initial release
// ============================================================================
package hazard_unit_pkg;

  // RV32I major opcodes (instruction bits 6:0)
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Hazard controller states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hz_state_t;

  // rs1 is read by everything except the upper-immediate and JAL forms
  function automatic logic uses_rs1(input logic [6:0] opcode);
    return !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
  endfunction

  // rs2 is read only by register-register ALU ops, stores and branches
  function automatic logic uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter
// Event counter that increments on inc and sticks at all-ones.
// Revision: 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count events, holding at the maximum instead of wrapping
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// hazard_unit
// Pipeline hazard controller: load-use bubbles, taken-branch flushes,
// data-memory wait freezing with timeout, and stall/flush event counters.
// Revision: 1.0  initial release
// ============================================================================
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [31:0]      instruction_ID,
  input  logic [31:0]      instruction_EX,
  input  logic             MemRead_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Wide enough to hold TIMEOUT_CYCLES itself
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_next;

  logic [6:0] opcode_id;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic [4:0] rd_ex;
  logic       load_use;
  logic       mem_stall;
  logic       stall_inc;
  logic       flush_inc;

  // Fields of the instruction words that hazard detection never looks at
  logic unused_fields;
  assign unused_fields = ^{instruction_ID[31:25], instruction_ID[14:7],
                           instruction_EX[31:12], instruction_EX[6:0]};

  assign opcode_id = instruction_ID[6:0];
  assign rs1_id    = instruction_ID[19:15];
  assign rs2_id    = instruction_ID[24:20];
  assign rd_ex     = instruction_EX[11:7];
  assign wait_next = wait_cnt + 1'b1;

  // Hazard conditions; x0 is never a real dependency
  always_comb begin
    load_use  = MemRead_EX && (rd_ex != 5'd0) &&
                ((uses_rs1(opcode_id) && (rs1_id == rd_ex)) ||
                 (uses_rs2(opcode_id) && (rs2_id == rd_ex)));
    mem_stall = dmem_req_MEM && !dmem_ready;
  end

  // Priority decode of pipeline controls: error > memory wait > branch > load-use
  always_comb begin
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    id_ex_we    = 1'b1;
    ex_mem_we   = 1'b1;
    mem_wb_we   = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (arst) begin
      // Leave the pipeline free-running while reset is held
    end else if (state == ST_ERROR) begin
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
    end else if (mem_stall) begin
      // Freeze the whole pipeline; a branch in EX is held and taken on release
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      id_ex_we  = 1'b0;
      ex_mem_we = 1'b0;
      mem_wb_we = 1'b0;
      stall_inc = 1'b1;
    end else if (branch_taken_EX) begin
      // The younger instructions are on the wrong path, so load-use is moot
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      flush_inc   = 1'b1;
    end else if (load_use) begin
      // One bubble: the load moves to MEM next cycle and forwarding takes over
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      flush_id_ex = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  // Memory-wait FSM with timeout watchdog; ERROR is only left through reset
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state <= ST_RUN;
          end else if (wait_next == WAIT_LIMIT) begin
            state       <= ST_ERROR;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        ST_ERROR: begin
          mem_timeout <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .arst  (arst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .arst  (arst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
// tb_hazard_unit
// Directed and randomized bench for hazard_unit with a behavioural model.
// Revision: 1.0  initial release
// ============================================================================
module tb_hazard_unit;

  localparam int TMO   = 4;
  localparam int CW    = 4;
  localparam int CMAX  = 15;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic [31:0] instruction_ID = NOP;
  logic [31:0] instruction_EX = NOP;
  logic        MemRead_EX = 1'b0;
  logic        branch_taken_EX = 1'b0;
  logic        dmem_req_MEM = 1'b0;
  logic        dmem_ready = 1'b1;
  logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic        flush_if_id, flush_id_ex, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit m_err;
  bit m_wait;
  int m_waited;
  int m_stalls;
  int m_flushes;

  hazard_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .arst(arst),
    .instruction_ID(instruction_ID), .instruction_EX(instruction_EX),
    .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .mem_timeout(mem_timeout),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] op, input int rd, input int rs1, input int rs2);
    logic [4:0] d, a, b;
    d = 5'(rd); a = 5'(rs1); b = 5'(rs2);
    return {7'b0, b, a, 3'b000, d, op};
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ctl_vec();
    return {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, flush_if_id, flush_id_ex, mem_timeout};
  endfunction

  // Apply one cycle of inputs, compare against the model, then advance a clock
  task automatic step(input logic [31:0] id, input logic [31:0] ex,
                      input logic mr, input logic br, input logic req, input logic rdy);
    logic [6:0] op;
    int rd, r1, r2;
    bit u1, u2, lu, ms;
    logic [7:0] exp;
    instruction_ID = id; instruction_EX = ex; MemRead_EX = mr;
    branch_taken_EX = br; dmem_req_MEM = req; dmem_ready = rdy;
    #3;
    op = id[6:0];
    rd = int'(ex[11:7]); r1 = int'(id[19:15]); r2 = int'(id[24:20]);
    u1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
    u2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
    lu = mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
    ms = req && !rdy;
    if (m_err)    exp = 8'b00000_00_1;
    else if (ms)  exp = 8'b00000_00_0;
    else if (br)  exp = 8'b11111_11_0;
    else if (lu)  exp = 8'b00111_01_0;
    else          exp = 8'b11111_00_0;
    chk("ctl", {24'b0, ctl_vec()}, {24'b0, exp});
    chk("stall_count", {28'b0, stall_count}, 32'(sat(m_stalls)));
    chk("flush_count", {28'b0, flush_count}, 32'(sat(m_flushes)));
    @(posedge clk);
    if (!m_err && (ms || (lu && !br))) m_stalls++;
    if (!m_err && !ms && br) m_flushes++;
    if (m_err) begin
      // stays in error
    end else if (m_wait) begin
      if (rdy) m_wait = 0;
      else begin
        m_waited++;
        if (m_waited == TMO) m_err = 1;
      end
    end else if (ms) begin
      m_wait = 1;
      m_waited = 0;
    end
    #1;
  endtask

  // Pulse reset away from the clock edge while hazard-inducing inputs are applied
  task automatic do_reset();
    #2;
    arst = 1'b1;
    instruction_ID = mk(7'b0110011, 3, 1, 2); instruction_EX = mk(7'b0000011, 1, 0, 0);
    MemRead_EX = 1'b1; branch_taken_EX = 1'b1; dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
    #1;
    chk("rst_ctl", {24'b0, ctl_vec()}, {24'b0, 8'b11111_00_0});
    chk("rst_stall", {28'b0, stall_count}, 32'd0);
    chk("rst_flush", {28'b0, flush_count}, 32'd0);
    @(posedge clk);
    #1;
    arst = 1'b0;
    m_err = 0; m_wait = 0; m_waited = 0; m_stalls = 0; m_flushes = 0;
  endtask

  initial begin
    logic [6:0] ops [9];
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    @(posedge clk);
    do_reset();

    // Load-use on rs1 of an add: one bubble
    step(mk(7'b0110011, 3, 1, 2), mk(7'b0000011, 1, 0, 0), 1, 0, 0, 1);
    step(NOP, mk(7'b0110011, 3, 1, 2), 0, 0, 0, 1);
    chk("lu_stall_count", {28'b0, stall_count}, 32'd1);
    // Load-use through rs2 of a store
    step(mk(7'b0100011, 0, 4, 7), mk(7'b0000011, 7, 0, 0), 1, 0, 0, 1);
    // Loads to x0 and lui field aliasing do not stall
    step(mk(7'b0110011, 3, 0, 0), mk(7'b0000011, 0, 0, 0), 1, 0, 0, 1);
    step(mk(7'b0110111, 5, 5, 5), mk(7'b0000011, 5, 0, 0), 1, 0, 0, 1);
    // I-type does not read rs2
    step(mk(7'b0010011, 2, 9, 6), mk(7'b0000011, 6, 0, 0), 1, 0, 0, 1);

    // Branch overrides load-use
    do_reset();
    step(mk(7'b0110011, 3, 1, 2), mk(7'b0000011, 1, 0, 0), 1, 1, 0, 1);
    chk("br_flush_count", {28'b0, flush_count}, 32'd1);
    chk("br_stall_count", {28'b0, stall_count}, 32'd0);

    // Memory wait freezes a taken branch, released with a flush
    do_reset();
    for (int i = 0; i < 3; i++) step(NOP, mk(7'b1100011, 0, 1, 2), 0, 1, 1, 0);
    step(NOP, mk(7'b1100011, 0, 1, 2), 0, 1, 1, 1);
    chk("mw_stall_count", {28'b0, stall_count}, 32'd3);
    chk("mw_flush_count", {28'b0, flush_count}, 32'd1);

    // Timeout into ERROR, then reset recovers
    do_reset();
    for (int i = 0; i < TMO + 1; i++) step(NOP, NOP, 0, 0, 1, 0);
    chk("to_flag", {31'b0, mem_timeout}, 32'd1);
    step(NOP, NOP, 0, 0, 1, 1);
    step(NOP, NOP, 0, 1, 0, 1);
    do_reset();
    chk("to_cleared", {31'b0, mem_timeout}, 32'd0);
    step(NOP, NOP, 0, 0, 0, 1);

    // Counter saturation
    for (int i = 0; i < 20; i++) step(mk(7'b0110011, 3, 1, 2), mk(7'b0000011, 1, 0, 0), 1, 0, 0, 1);
    chk("sat_stall_count", {28'b0, stall_count}, 32'd15);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] id, ex;
      if ($urandom_range(0, 99) < 3) do_reset();
      id = mk(ops[$urandom_range(0, 8)], int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      ex = mk(7'b0000011, int'($urandom_range(0, 3)), 0, 0);
      step(id, ex, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 20),
           1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 70));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
